// File: rtl/triangle_area.sv
// Signed-area (edge cross product) of a screen-space triangle; 3-cycle latency, 1 triangle/clock.
// No backpressure: a valid flag rides alongside the data and the pipe never stalls.
`timescale 1ns/1ps
module triangle_area (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [2:0][1:0][16:0]  vertices_in,
  output logic                   valid_out,
  output logic                   negative_out,
  output logic [33:0]            area_out
);

  logic [16:0] x0, y0, x1, y1, x2, y2;

  assign x0 = vertices_in[0][0];
  assign y0 = vertices_in[0][1];
  assign x1 = vertices_in[1][0];
  assign y1 = vertices_in[1][1];
  assign x2 = vertices_in[2][0];
  assign y2 = vertices_in[2][1];

  // Stage 1: edge vectors relative to vertex 0 (coordinates are unsigned, so zero-extend)
  logic signed [17:0] s1_dx1, s1_dy2, s1_dx2, s1_dy1;
  logic               s1_vld;

  // Stage 2: the two cross-product terms, exact in 36 bits
  logic signed [35:0] s2_p0, s2_p1;
  logic               s2_vld;

  // Stage 3: combinational difference feeding the output registers
  logic signed [36:0] c_d;

  assign c_d = 37'(s2_p0) - 37'(s2_p1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_dx1       <= '0;
      s1_dy2       <= '0;
      s1_dx2       <= '0;
      s1_dy1       <= '0;
      s1_vld       <= 1'b0;
      s2_p0        <= '0;
      s2_p1        <= '0;
      s2_vld       <= 1'b0;
      valid_out    <= 1'b0;
      negative_out <= 1'b0;
      area_out     <= '0;
    end else begin
      s1_dx1       <= $signed({1'b0, x1}) - $signed({1'b0, x0});
      s1_dy2       <= $signed({1'b0, y2}) - $signed({1'b0, y0});
      s1_dx2       <= $signed({1'b0, x2}) - $signed({1'b0, x0});
      s1_dy1       <= $signed({1'b0, y1}) - $signed({1'b0, y0});
      s1_vld       <= valid_in;

      s2_p0        <= 36'(s1_dx1) * 36'(s1_dy2);
      s2_p1        <= 36'(s1_dx2) * 36'(s1_dy1);
      s2_vld       <= s1_vld;

      // |C| < 2^35 for any in-range triangle, so halving always fits in 34 bits
      negative_out <= c_d[36];
      area_out     <= 34'((c_d[36] ? -c_d : c_d) >>> 1);
      valid_out    <= s2_vld;
    end
  end

endmodule

// File: tb/tb_triangle_area.sv
// Bench for triangle_area: directed triangles, a short random burst and a mid-stream reset,
// checked every cycle against an integer model plus literal expectations.
`timescale 1ns/1ps
module tb_triangle_area;

  typedef logic [2:0][1:0][16:0] vert_t;

  typedef struct {
    logic        v;
    logic        neg;
    logic [33:0] area;
    int          tag;
  } stage_t;

  logic        clk_in;
  logic        rst_in;
  logic        valid_in;
  vert_t       vertices_in;
  logic        valid_out;
  logic        negative_out;
  logic [33:0] area_out;

  int n_chk;
  int n_pass;
  int cur_tag;
  stage_t m [3];

  localparam logic [33:0] LIT_AREA [5] = '{34'h0_1DA0_0000, 34'h0_0263_F400, 34'h0_1DA0_0000,
                                           34'h0_0000_0000, 34'h1_FFFE_0000};
  localparam logic        LIT_NEG  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  triangle_area dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .vertices_in  (vertices_in),
    .valid_out    (valid_out),
    .negative_out (negative_out),
    .area_out     (area_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Exact cross product with wide integers, then the output rules applied directly
  function automatic void model(input vert_t v, output logic neg, output logic [33:0] area);
    longint c;
    c = (longint'(v[1][0]) - longint'(v[0][0])) * (longint'(v[2][1]) - longint'(v[0][1]))
      - (longint'(v[2][0]) - longint'(v[0][0])) * (longint'(v[1][1]) - longint'(v[0][1]));
    neg = (c < 0);
    if (c < 0) c = -c;
    area = 34'(c / 2);
  endfunction

  function automatic vert_t mk(input logic [16:0] x0, input logic [16:0] y0,
                               input logic [16:0] x1, input logic [16:0] y1,
                               input logic [16:0] x2, input logic [16:0] y2);
    vert_t v;
    v[0][0] = x0; v[0][1] = y0;
    v[1][0] = x1; v[1][1] = y1;
    v[2][0] = x2; v[2][1] = y2;
    return v;
  endfunction

  // Latency model: what the DUT sampled 1, 2 and 3 edges ago
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 3; i++) begin
        m[i].v = 1'b0; m[i].neg = 1'b0; m[i].area = '0; m[i].tag = -1;
      end
    end else begin
      m[2] = m[1];
      m[1] = m[0];
      m[0].v = valid_in;
      model(vertices_in, m[0].neg, m[0].area);
      m[0].tag = valid_in ? cur_tag : -1;
    end
  end

  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("rst_valid", 64'(valid_out), 64'(0));
      chk("rst_neg",   64'(negative_out), 64'(0));
      chk("rst_area",  64'(area_out), 64'(0));
    end else begin
      chk("valid", 64'(valid_out), 64'(m[2].v));
      if (m[2].v) begin
        chk("neg",  64'(negative_out), 64'(m[2].neg));
        chk("area", 64'(area_out), 64'(m[2].area));
        if (m[2].tag >= 0) begin
          chk("lit_neg",  64'(negative_out), 64'(LIT_NEG[m[2].tag]));
          chk("lit_area", 64'(area_out), 64'(LIT_AREA[m[2].tag]));
        end
      end
    end
  end

  task automatic drive(input logic v, input vert_t t, input int tag);
    @(posedge clk_in);
    #1;
    valid_in    = v;
    vertices_in = t;
    cur_tag     = tag;
  endtask

  vert_t t1, t2, t1s, col, ext, rv;
  int    lat;

  initial begin
    n_chk = 0; n_pass = 0; cur_tag = -1;
    rst_in = 1'b1; valid_in = 1'b0; vertices_in = '0;
    t1  = mk(17'h06000, 17'h00400, 17'h00000, 17'h05300, 17'h0C000, 17'h05300);
    t2  = mk(17'h01E00, 17'h04BE0, 17'h003C0, 17'h00D80, 17'h003C0, 17'h03C20);
    t1s = mk(17'h06000, 17'h00400, 17'h0C000, 17'h05300, 17'h00000, 17'h05300);
    col = mk(17'h00000, 17'h00000, 17'h00100, 17'h00100, 17'h00200, 17'h00200);
    ext = mk(17'h00000, 17'h00000, 17'h1FFFF, 17'h00000, 17'h00000, 17'h1FFFF);

    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    drive(1'b1, t1, 0);
    drive(1'b1, t2, 1);
    drive(1'b1, t1s, 2);
    drive(1'b0, t2, -1);
    drive(1'b1, col, 3);
    drive(1'b1, ext, 4);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 2; j++)
          rv[i][j] = 17'($urandom);
      drive($urandom_range(0, 3) != 0, rv, -1);
    end
    repeat (3) drive(1'b0, '0, -1);

    // Fill the pipe, then reset asynchronously between clock edges
    drive(1'b1, t1, -1);
    drive(1'b1, ext, -1);
    drive(1'b1, t2, -1);
    drive(1'b1, t1s, -1);
    #3 rst_in = 1'b1;
    #1;
    chk("async_rst_valid", 64'(valid_out), 64'(0));
    chk("async_rst_neg",   64'(negative_out), 64'(0));
    chk("async_rst_area",  64'(area_out), 64'(0));
    repeat (2) @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    rst_in   = 1'b0;
    repeat (4) drive(1'b0, t1, -1);

    // First valid after release must surface exactly 3 edges later
    drive(1'b1, t2, 1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_in);
      #1;
      if (i == 1) valid_in = 1'b0;
      if (valid_out && lat == 0) lat = i;
    end
    chk("latency_after_reset", 64'(lat), 64'(3));

    repeat (2) @(posedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
